regfile_mp_scoreboard: RTL



---
 rtl/rv_pkg.sv | 29 ++
 rtl/regfile_scoreboard.sv | 45 ++++
 rtl/regfile_mp_scoreboard.sv | 67 ++++++
 3 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: shared register-file constants and the priority port-match helper
package rv_pkg;
    localparam int RV_XLEN  = 32;
    localparam int RV_NREGS = 32;
    localparam int RV_AW    = $clog2(RV_NREGS);
    // Match helper works on vectors padded to these maxima so one function serves every port count
    localparam int RV_MAXP  = 8;
    localparam int RV_MAXAW = 8;
    typedef logic [$clog2(RV_MAXP)-1:0] pidx_t;
    typedef struct packed {
        logic  hit;
        pidx_t idx;
    } match_t;
    // Highest-index enabled port whose address equals addr
    function automatic match_t port_prio_match(
        input logic [RV_MAXAW-1:0]         addr,
        input logic [RV_MAXP-1:0]          en_vec,
        input logic [RV_MAXP*RV_MAXAW-1:0] addr_vec
    );
        match_t m;
        m = '0;
        for (int i = 0; i < RV_MAXP; i++)
            if (en_vec[i] && addr_vec[i*RV_MAXAW +: RV_MAXAW] == addr) begin
                m.hit = 1'b1;
                m.idx = pidx_t'(i);
            end
        return m;
    endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits (issue sets, write-back clears, flush/reset clear all)
//   clk, rst          clock, synchronous active-high reset
//   iss_en, iss_rd    producer dispatch strobes and destinations
//   wr_en, wr_addr    write-back strobes and destinations
//   flush             discard all pending producers
//   busy_vec          scoreboard state; bit 0 stays 0
module regfile_scoreboard
    import rv_pkg::*;
#(
    parameter int NREGS = RV_NREGS,
    parameter int NWR   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NWR-1:0]    iss_en,
    input  logic [NWR*AW-1:0] iss_rd,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              flush,
    output logic [NREGS-1:0]  busy_vec
);
    logic [RV_MAXP*RV_MAXAW-1:0] ia_pad, wa_pad;
    logic [NREGS-1:0]            iss_hit, wr_hit;
    always_comb begin
        ia_pad = '0;
        wa_pad = '0;
        for (int j = 0; j < NWR; j++) begin
            ia_pad[j*RV_MAXAW +: RV_MAXAW] = RV_MAXAW'(iss_rd[j*AW +: AW]);
            wa_pad[j*RV_MAXAW +: RV_MAXAW] = RV_MAXAW'(wr_addr[j*AW +: AW]);
        end
        for (int r = 0; r < NREGS; r++) begin
            iss_hit[r] = port_prio_match(RV_MAXAW'(r), RV_MAXP'(iss_en), ia_pad).hit;
            wr_hit[r]  = port_prio_match(RV_MAXAW'(r), RV_MAXP'(wr_en), wa_pad).hit;
        end
    end
    // Issue beats a same-cycle write-back clear: the new producer owns the register
    always_ff @(posedge clk) begin
        if (rst || flush)
            busy_vec <= '0;
        else
            for (int r = 1; r < NREGS; r++)
                busy_vec[r] <= iss_hit[r] ? 1'b1 : wr_hit[r] ? 1'b0 : busy_vec[r];
    end
endmodule

// File: rtl/regfile_mp_scoreboard.sv
// regfile_mp_scoreboard: multi-port register file with write-to-read bypass and RAW busy scoreboard
//   rd_addr/rd_data/rd_busy   NRD combinational read ports
//   wr_en/wr_addr/wr_data     NWR write-back ports, highest index wins on collision
//   iss_en/iss_rd, flush      scoreboard set / flush controls
//   busy_vec                  raw scoreboard state
module regfile_mp_scoreboard
    import rv_pkg::*;
#(
    parameter int XLEN   = RV_XLEN,
    parameter int NREGS  = RV_NREGS,
    parameter int NRD    = 4,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic [NWR-1:0]      iss_en,
    input  logic [NWR*AW-1:0]   iss_rd,
    input  logic                flush,
    output logic [NREGS-1:0]    busy_vec
);
    logic [XLEN-1:0]             regs [NREGS];
    logic [RV_MAXP*RV_MAXAW-1:0] wa_pad;
    match_t                      wm [NREGS];
    match_t                      rm [NRD];
    logic [AW-1:0]               ra [NRD];
    logic                        rv [NRD];
    logic                        bh [NRD];
    regfile_scoreboard #(.NREGS(NREGS), .NWR(NWR), .AW(AW)) u_sb (
        .clk(clk), .rst(rst), .iss_en(iss_en), .iss_rd(iss_rd),
        .wr_en(wr_en), .wr_addr(wr_addr), .flush(flush), .busy_vec(busy_vec)
    );
    always_comb begin
        wa_pad = '0;
        for (int j = 0; j < NWR; j++)
            wa_pad[j*RV_MAXAW +: RV_MAXAW] = RV_MAXAW'(wr_addr[j*AW +: AW]);
        for (int r = 0; r < NREGS; r++)
            wm[r] = port_prio_match(RV_MAXAW'(r), RV_MAXP'(wr_en), wa_pad);
    end
    // Out-of-range write addresses never match a stored register, so they drop naturally
    always_ff @(posedge clk) begin
        if (rst)
            for (int r = 0; r < NREGS; r++) regs[r] <= '0;
        else
            for (int r = 1; r < NREGS; r++)
                if (wm[r].hit) regs[r] <= wr_data[int'(wm[r].idx)*XLEN +: XLEN];
    end
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            ra[k] = rd_addr[k*AW +: AW];
            rv[k] = ra[k] != '0 && int'(ra[k]) < NREGS;
            rm[k] = port_prio_match(RV_MAXAW'(ra[k]), RV_MAXP'(wr_en), wa_pad);
            bh[k] = BYPASS != 0 && rm[k].hit;
            rd_data[k*XLEN +: XLEN] = !rv[k] ? '0 : bh[k] ? wr_data[int'(rm[k].idx)*XLEN +: XLEN] : regs[ra[k]];
            rd_busy[k] = rv[k] && busy_vec[ra[k]] && !bh[k];
        end
    end
endmodule
